sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Initiator side of the single-port synchronous SRAM macro interface (RW0_*) used by the cache data and tag arrays.
- Converts a valid/ready request stream (read/write, byte-lane mask) into RW0 port cycles.
- Captures the 1-cycle-latency read data into a 2-entry response buffer under valid/ready.
- Optionally zero-fills the whole array after reset, before accepting any traffic.

Parameters:
- ADDR_BITS, 9, SRAM address width; depth = 2^ADDR_BITS.
- DATA_BITS, 256, SRAM word width.
- MASK_BITS, 32, write-mask lanes; DATA_BITS % MASK_BITS == 0; lane width = DATA_BITS/MASK_BITS.
- INIT_ON_RESET, 1, 1 = zero-fill every address after reset; 0 = go straight to RUN.

Ports:
- clock  in  1  single clock; the SRAM macro is clocked by the same net.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready (fire).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_BITS  word address.
- req_wmask  in  MASK_BITS  lane enables, used for writes only.
- req_wdata  in  DATA_BITS  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes resp_data when resp_valid && resp_ready.
- resp_data  out  DATA_BITS  read data, in request order.
- init_done  out  1  high once RUN is reached; stays high until reset.
- RW0_addr  out  ADDR_BITS  to macro.
- RW0_en  out  1  to macro.
- RW0_wmode  out  1  to macro.
- RW0_wmask  out  MASK_BITS  to macro.
- RW0_wdata  out  DATA_BITS  to macro.
- RW0_rdata  in  DATA_BITS  from macro; valid the cycle after a read-enable.

Behaviour:
- Reset is asynchronous and active-high. On assertion:
  - FSM goes to INIT (INIT_ON_RESET=1) or RUN (INIT_ON_RESET=0).
  - init counter = 0, rd_pend = 0, response buffer emptied.
  - Outputs: req_ready=0, resp_valid=0, resp_data=0, init_done=0, RW0_en=0, RW0_wmode=0, RW0_addr/wmask/wdata=0.
  - A read in flight when reset asserts is discarded; it never produces a response.
- INIT state:
  - Each cycle drives RW0_en=1, RW0_wmode=1, RW0_addr=counter, RW0_wmask=all ones, RW0_wdata=0; counter increments.
  - On counter == 2^ADDR_BITS-1, go to RUN. Fill takes exactly 2^ADDR_BITS cycles.
  - req_ready=0 throughout INIT.
- RUN state:
  - init_done=1 from the first RUN cycle; with INIT_ON_RESET=0 that is the first clock edge after reset deasserts.
  - req_ready = credit_ok, independent of req_valid and req_write.
  - credit_ok = (rd_pend + buf_count − (resp_valid && resp_ready)) < 2.
- On fire, the RW0 port is driven combinationally in the same cycle:
  - RW0_en=1, RW0_wmode=req_write, RW0_addr=req_addr.
  - RW0_wmask = req_write ? req_wmask : 0.
  - RW0_wdata=req_wdata.
- When there is no fire in RUN: RW0_en=0 and all other RW0 outputs = 0.
- Reads:
  - Read fire sets rd_pend for the next cycle.
  - In that next cycle RW0_rdata is pushed into the buffer; rd_pend clears unless another read fires in the same cycle.
  - Minimum latency: read fire at cycle N → resp_valid at N+1 with resp_data valid. resp_data is the buffer head, registered-free mux.
  - Sustained throughput is one read per cycle while resp_ready=1.
- Writes produce no response. A write and a buffered read response may be in progress in the same cycle.
- The buffer is a 2-entry FIFO with in-order responses.
  - Push and pop in the same cycle is legal when full.
  - The credit rule guarantees no overflow, so captured data is never dropped.
- resp_valid, once asserted, holds and resp_data stays stable until the handshake completes.
- A read the cycle after a write to the same address returns the newly written data, because writes retire at the clock edge.

Test Plan:
- INIT_ON_RESET=1, ADDR_BITS=9: release reset → exactly 512 writes to addresses 0..511 with wdata=0 and mask=all ones; init_done rises on cycle 512; req_ready=0 before that.
- Write addr 5, mask 0x0000000F, data all-ones, then read addr 5 with resp_ready=1 → resp_valid one cycle after read fire; resp_data has bits [31:0]=0xFFFFFFFF and all other bits 0.
- Back-to-back reads to addr 1,2,3,4 with resp_ready=1 → req_ready stays 1; responses arrive on consecutive cycles in order 1,2,3,4.
- resp_ready=0, issue 3 reads → first two accepted; req_ready drops; resp_data holds the addr-1 data stably; after raising resp_ready, the third read is accepted and all three return in order.
- Assert reset one cycle after a read fire → no response ever appears; init restarts from address 0; resp_valid stays 0 and init_done stays 0 during reset.
- INIT_ON_RESET=0: req_ready and init_done are 1 on the first edge after reset; the first request fires with no fill cycles.

Source files
------------

// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: request/response handshake bundle between a client and sram_port_ctrl
// master drives requests and resp_ready; slave (the controller) drives req_ready and the response.
interface sram_port_ctrl_if #(
  parameter int ADDR_BITS = 9,
  parameter int DATA_BITS = 256,
  parameter int MASK_BITS = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  logic [MASK_BITS-1:0] req_wmask;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_data;
  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: initiator for a single-port synchronous SRAM macro (RW0_*)
// RW0_clk/reset: shared macro clock, async active-high reset
// bus: request stream in, in-order read responses out (2-entry buffer)
// init_done: high once the optional post-reset zero fill has finished
// RW0_*: macro port, driven combinationally from an accepted request or the fill counter
module sram_port_ctrl #(
  parameter int ADDR_BITS     = 9,
  parameter int DATA_BITS     = 256,
  parameter int MASK_BITS     = 32,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                 RW0_clk,
  input  logic                 reset,
  sram_port_ctrl_if.slave      bus,
  output logic                 init_done,
  output logic [ADDR_BITS-1:0] RW0_addr,
  output logic                 RW0_en,
  output logic                 RW0_wmode,
  output logic [MASK_BITS-1:0] RW0_wmask,
  output logic [DATA_BITS-1:0] RW0_wdata,
  input  logic [DATA_BITS-1:0] RW0_rdata
);
  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t               state;
  logic [ADDR_BITS-1:0] cnt;
  logic                 rd_pend;
  logic [DATA_BITS-1:0] buf_mem [2];
  logic                 wp, rp;
  logic [1:0]           count;
  logic                 fire, init_wr, pop, buf_pop, push;
  logic [2:0]           occ;
  assign fire = bus.req_valid && bus.req_ready;
  // the fill is gated by reset so the macro sees no write while reset is held
  assign init_wr = state == S_INIT && !reset;
  // an empty buffer forwards the macro output directly, giving one-cycle read latency
  assign bus.resp_valid = count != 2'd0 || rd_pend;
  assign bus.resp_data  = count != 2'd0 ? buf_mem[rp] : rd_pend ? RW0_rdata : '0;
  assign pop     = bus.resp_valid && bus.resp_ready;
  assign buf_pop = pop && count != 2'd0;
  assign push    = rd_pend && !(pop && count == 2'd0);
  // outstanding reads after this cycle; a new read is allowed while it stays below 2
  assign occ = 3'(rd_pend) + 3'(count) - 3'(pop);
  assign bus.req_ready = init_done && occ < 3'd2;
  assign RW0_en    = init_wr || fire;
  assign RW0_wmode = init_wr || (fire && bus.req_write);
  assign RW0_addr  = init_wr ? cnt : fire ? bus.req_addr : '0;
  assign RW0_wmask = init_wr ? '1 : (fire && bus.req_write) ? bus.req_wmask : '0;
  assign RW0_wdata = fire ? bus.req_wdata : '0;
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_ON_RESET != 0 ? S_INIT : S_RUN;
      cnt       <= '0;
      init_done <= 1'b0;
      rd_pend   <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (state == S_INIT) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state     <= S_RUN;
          init_done <= 1'b1;
        end
      end else
        init_done <= 1'b1;
      rd_pend <= fire && !bus.req_write;
      if (push) wp <= ~wp;
      if (buf_pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(buf_pop);
    end
  end
  always_ff @(posedge RW0_clk)
    if (push) buf_mem[wp] <= RW0_rdata;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: randomized scoreboard bench for sram_port_ctrl with a behavioural SRAM macro
module tb_sram_port_ctrl;
  localparam int AB = 9, DB = 256, MB = 32, LW = DB / MB, DEPTH = 1 << AB;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, rst1;
  int checks = 0, failures = 0;
  sram_port_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .MASK_BITS(MB)) b();
  logic          init_done, RW0_en, RW0_wmode;
  logic [AB-1:0] RW0_addr;
  logic [MB-1:0] RW0_wmask;
  logic [DB-1:0] RW0_wdata, RW0_rdata;
  sram_port_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .MASK_BITS(MB), .INIT_ON_RESET(1)) dut (
    .RW0_clk(clk), .reset(reset), .bus(b), .init_done(init_done),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata));
  sram_port_ctrl_if #(.ADDR_BITS(4), .DATA_BITS(DB), .MASK_BITS(MB)) b1();
  logic          init_done1, RW0_en1, RW0_wmode1;
  logic [3:0]    RW0_addr1;
  logic [MB-1:0] RW0_wmask1;
  logic [DB-1:0] RW0_wdata1, RW0_rdata1;
  sram_port_ctrl #(.ADDR_BITS(4), .DATA_BITS(DB), .MASK_BITS(MB), .INIT_ON_RESET(0)) dut1 (
    .RW0_clk(clk), .reset(rst1), .bus(b1), .init_done(init_done1),
    .RW0_addr(RW0_addr1), .RW0_en(RW0_en1), .RW0_wmode(RW0_wmode1),
    .RW0_wmask(RW0_wmask1), .RW0_wdata(RW0_wdata1), .RW0_rdata(RW0_rdata1));
  logic [DB-1:0] sram [0:DEPTH-1];
  always @(posedge clk)
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < MB; l++)
          if (RW0_wmask[l]) sram[RW0_addr][l*LW +: LW] <= RW0_wdata[l*LW +: LW];
      end else
        RW0_rdata <= sram[RW0_addr];
    end
  task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  logic [DB-1:0] ref_mem [0:DEPTH-1];
  logic [DB-1:0] exp_q [$];
  logic [DB-1:0] bm;
  always @(negedge clk) begin
    if (reset) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (init_done) begin
      if (b.req_valid && b.req_ready) begin
        chk("rw0_fire_ctl", {RW0_en, RW0_wmode, RW0_addr}, {1'b1, b.req_write, b.req_addr});
        chk("rw0_fire_wmask", RW0_wmask, b.req_write ? b.req_wmask : '0);
        chk("rw0_fire_wdata", RW0_wdata, b.req_wdata);
        if (b.req_write) begin
          bm = '0;
          for (int l = 0; l < MB; l++) if (b.req_wmask[l]) bm[l*LW +: LW] = '1;
          ref_mem[b.req_addr] = (ref_mem[b.req_addr] & ~bm) | (b.req_wdata & bm);
        end else
          exp_q.push_back(ref_mem[b.req_addr]);
      end else
        chk("rw0_idle", DB'({RW0_en, RW0_wmode, RW0_addr, RW0_wmask}) | RW0_wdata, '0);
    end
  end
  int fill_idx;
  bit seen_done;
  always @(negedge clk) begin
    if (reset) begin
      fill_idx = 0;
      seen_done = 0;
      chk("reset_outputs", DB'({b.resp_valid, init_done, b.req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask}) | RW0_wdata | b.resp_data, '0);
    end else if (!init_done) begin
      chk("fill_port", {b.req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask}, {1'b0, 1'b1, 1'b1, AB'(fill_idx), {MB{1'b1}}});
      chk("fill_wdata", RW0_wdata, '0);
      fill_idx++;
    end else if (!seen_done) begin
      seen_done = 1;
      chk("fill_cycles", fill_idx, DEPTH);
    end
  end
  bit hold;
  logic [DB-1:0] held, e;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold = 0;
    end else begin
      if (hold) begin
        chk("resp_hold_valid", b.resp_valid, 1);
        chk("resp_hold_data", b.resp_data, held);
      end
      hold = 0;
      if (b.resp_valid) begin
        if (b.resp_ready) begin
          if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("resp_data", b.resp_data, e);
          end
        end else begin
          hold = 1;
          held = b.resp_data;
        end
      end
    end
  end
  task automatic issue(input bit w, input logic [AB-1:0] a, input logic [MB-1:0] m, input logic [DB-1:0] d, input bit drain);
    int n = 0;
    b.req_valid = 1; b.req_write = w; b.req_addr = a; b.req_wmask = m; b.req_wdata = d;
    @(negedge clk);
    while (!b.req_ready && n < 100) begin
      @(posedge clk); #1;
      if (drain) b.resp_ready = 1;
      n++;
      @(negedge clk);
    end
    chk("req_accept", b.req_ready, 1);
    @(posedge clk); #1;
    b.req_valid = 0;
  endtask
  function automatic logic [DB-1:0] rnd_data();
    logic [DB-1:0] r;
    for (int i = 0; i < DB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 700) begin @(negedge clk); n++; end
    chk("init_done_reached", init_done, 1);
    @(posedge clk); #1;
  endtask
  logic [DB-1:0] wd [0:15];
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; rst1 = 1; RW0_rdata1 = '0;
    b.req_valid = 0; b.req_write = 0; b.req_addr = '0; b.req_wmask = '0; b.req_wdata = '0; b.resp_ready = 1;
    b1.req_valid = 0; b1.req_write = 0; b1.req_addr = '0; b1.req_wmask = '0; b1.req_wdata = '0; b1.resp_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    wait_init();
    issue(1, 9'd5, 32'h0000_000F, '1, 0);
    issue(0, 9'd5, '0, '0, 0);
    @(negedge clk);
    chk("lat_valid", b.resp_valid, 1);
    chk("lat_data", b.resp_data, DB'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      wd[i] = rnd_data();
      issue(1, AB'(i), '1, wd[i], 0);
    end
    b.req_valid = 1; b.req_write = 0;
    for (int i = 1; i <= 4; i++) begin
      b.req_addr = AB'(i);
      @(negedge clk);
      chk("b2b_ready", b.req_ready, 1);
      if (i > 1) begin
        chk("b2b_valid", b.resp_valid, 1);
        chk("b2b_data", b.resp_data, wd[i-1]);
      end
      @(posedge clk); #1;
    end
    b.req_valid = 0;
    @(negedge clk);
    chk("b2b_last", b.resp_data, wd[4]);
    @(posedge clk); #1;
    b.resp_ready = 0; b.req_valid = 1; b.req_addr = 9'd6;
    @(negedge clk);
    chk("stall_ready0", b.req_ready, 1);
    @(posedge clk); #1 b.req_addr = 9'd7;
    @(negedge clk);
    chk("stall_ready1", b.req_ready, 1);
    chk("stall_data1", b.resp_data, wd[6]);
    @(posedge clk); #1 b.req_addr = 9'd8;
    repeat (3) begin
      @(negedge clk);
      chk("stall_blocked", b.req_ready, 0);
      chk("stall_head", {b.resp_valid, b.resp_data[DB-2:0]}, {1'b1, wd[6][DB-2:0]});
      @(posedge clk); #1;
    end
    b.resp_ready = 1;
    @(negedge clk);
    chk("stall_release", b.req_ready, 1);
    chk("stall_out6", b.resp_data, wd[6]);
    @(posedge clk); #1 b.req_valid = 0;
    @(negedge clk);
    chk("stall_out7", b.resp_data, wd[7]);
    @(negedge clk);
    chk("stall_out8", b.resp_data, wd[8]);
    @(posedge clk); #1;
    issue(0, 9'd3, '0, '0, 0);
    reset = 1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 0;
    wait_init();
    for (int i = 0; i < 300; i++) begin
      b.resp_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else
        issue(1'($urandom_range(0, 1)), AB'($urandom_range(0, 15)), $urandom, rnd_data(), 1);
    end
    b.resp_ready = 1;
    repeat (4) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("nr_in_reset", {init_done1, b1.req_ready, RW0_en1}, 3'b000);
    @(posedge clk); #1;
    rst1 = 0;
    b1.req_valid = 1; b1.req_write = 1; b1.req_addr = 4'd3; b1.req_wmask = '1; b1.req_wdata = rnd_data();
    @(negedge clk);
    chk("nr_before_edge", {init_done1, b1.req_ready, RW0_en1}, 3'b000);
    @(negedge clk);
    chk("nr_after_edge", {init_done1, b1.req_ready, RW0_en1, RW0_wmode1, RW0_addr1}, {4'b1111, 4'd3});
    chk("nr_wdata", RW0_wdata1, b1.req_wdata);
    @(posedge clk); #1 b1.req_valid = 0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
